// File: rtl/serialize_pkg.sv
// Shared types for the word-to-bit serializer: FSM state encoding and the
// counter-width helper used by the top level and the bit counter.
package serialize_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Bits needed to hold W-1, the largest remaining-bit count.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serialize_word_to_bits_if.sv
// Word-in / bit-out handshake bundle for serialize_word_to_bits.
// Both sides use strict valid/ready: a transfer happens on a posedge where
// valid and ready are both high; valid never waits on ready, and ready may
// depend on the same side's state but never on the opposite valid.
interface serialize_word_to_bits_if #(
  parameter int W = 8
) ();

  logic         word_valid;
  logic [W-1:0] word_data;
  logic         word_ready;
  logic         bit_ready;
  logic         new_bit;
  logic         bit_valid;
  logic         bit_last;

  // master: the environment (word producer and bit consumer)
  modport master (
    output word_valid, word_data, bit_ready,
    input  word_ready, new_bit, bit_valid, bit_last
  );

  // slave: the serializer itself
  modport slave (
    input  word_valid, word_data, bit_ready,
    output word_ready, new_bit, bit_valid, bit_last
  );

endinterface

// File: rtl/serializer_bit_counter.sv
// Remaining-bit counter: loads W-1 when a word is taken, counts down on each
// non-final bit transfer, and flags zero while the final bit is on the wire.
module serializer_bit_counter #(
  parameter int W = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 load,
  input  logic                                 dec,
  output logic [serialize_pkg::cnt_width(W)-1:0] count,
  output logic                                 zero
);

  localparam int CW = serialize_pkg::cnt_width(W);
  localparam logic [CW-1:0] LOAD_VALUE = CW'(W - 1);

  // load wins over dec so a back-to-back word restarts the count cleanly
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VALUE;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/serialize_word_to_bits.sv
// Parallel-to-serial converter: takes W-bit words and emits them MSB first,
// one bit per clock, with no bubble between consecutive words.
module serialize_word_to_bits
  import serialize_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  serialize_word_to_bits_if.slave      bus,
  output state_t                       dbg_state,
  output logic [cnt_width(W)-1:0]      dbg_count
);

  localparam int CW = cnt_width(W);

  state_t         state;
  state_t         state_next;
  logic [W-1:0]   shift_reg;
  logic [CW-1:0]  count;
  logic           cnt_zero;
  logic           in_shift;
  logic           last;
  logic           bit_xfer;
  logic           ready;
  logic           accept;

  assign in_shift = (state == SHIFT);
  assign last     = in_shift & cnt_zero;
  assign bit_xfer = in_shift & bus.bit_ready;
  // Ready on the final-bit transfer lets the next word load with no gap.
  assign ready    = (state == IDLE) | (last & bus.bit_ready);
  assign accept   = bus.word_valid & ready;

  serializer_bit_counter #(
    .W (W)
  ) u_bit_counter (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .dec   (bit_xfer & ~last),
    .count (count),
    .zero  (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        shift_reg <= bus.word_data;
      end else if (bit_xfer && !last) begin
        shift_reg <= {shift_reg[W-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) state_next = SHIFT;
      end
      SHIFT: begin
        if (bit_xfer && last) state_next = accept ? SHIFT : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // new_bit is gated so the residue left in shift_reg after the LSB never shows
  assign bus.word_ready = ready;
  assign bus.bit_valid  = in_shift;
  assign bus.bit_last   = last;
  assign bus.new_bit    = in_shift & shift_reg[W-1];

  assign dbg_state = state;
  assign dbg_count = count;

endmodule

// File: tb/tb_serialize_word_to_bits.sv
// Directed bench for serialize_word_to_bits (W=8): reset, single word,
// back-to-back words, stalls, reset mid-word and idle behaviour.
module tb_serialize_word_to_bits;
  import serialize_pkg::*;

  localparam int W  = 8;
  localparam int CW = cnt_width(W);

  logic          clk;
  logic          rst;
  state_t        dbg_state;
  logic [CW-1:0] dbg_count;
  int            asserts;
  int            failures;

  serialize_word_to_bits_if #(.W(W)) bus ();

  serialize_word_to_bits #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state),
    .dbg_count (dbg_count)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.word_valid = 1'b0;
    bus.word_data  = 8'h00;
    bus.bit_ready  = 1'b0;
    tick();
    tick();
    @(negedge clk);
    asserts++; if (bus.bit_valid !== 1'b0) begin failures++; $display("FAIL reset_bit_valid: got %b expected 0", bus.bit_valid); end
    asserts++; if (bus.word_ready !== 1'b1) begin failures++; $display("FAIL reset_word_ready: got %b expected 1", bus.word_ready); end
    asserts++; if (bus.new_bit !== 1'b0) begin failures++; $display("FAIL reset_new_bit: got %b expected 0", bus.new_bit); end
    asserts++; if (bus.bit_last !== 1'b0) begin failures++; $display("FAIL reset_bit_last: got %b expected 0", bus.bit_last); end
    asserts++; if (dbg_state !== IDLE) begin failures++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE); end
    asserts++; if (dbg_count !== '0) begin failures++; $display("FAIL reset_count: got %0d expected 0", dbg_count); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] exp_word;
    exp_word = 8'hCA;
    bus.word_valid = 1'b1;
    bus.word_data  = exp_word;
    bus.bit_ready  = 1'b1;
    @(negedge clk);
    asserts++; if (bus.word_ready !== 1'b1) begin failures++; $display("FAIL basic_idle_ready: got %b expected 1", bus.word_ready); end
    tick();
    bus.word_valid = 1'b0;
    bus.word_data  = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      asserts++; if (bus.bit_valid !== 1'b1) begin failures++; $display("FAIL basic_valid[%0d]: got %b expected 1", i, bus.bit_valid); end
      asserts++; if (bus.new_bit !== exp_word[7-i]) begin failures++; $display("FAIL basic_bit[%0d]: got %b expected %b", i, bus.new_bit, exp_word[7-i]); end
      asserts++; if (bus.bit_last !== (i == 7)) begin failures++; $display("FAIL basic_last[%0d]: got %b expected %b", i, bus.bit_last, (i == 7)); end
      asserts++; if (bus.word_ready !== (i == 7)) begin failures++; $display("FAIL basic_ready[%0d]: got %b expected %b", i, bus.word_ready, (i == 7)); end
      tick();
    end
    @(negedge clk);
    asserts++; if (bus.bit_valid !== 1'b0) begin failures++; $display("FAIL basic_end_valid: got %b expected 0", bus.bit_valid); end
    asserts++; if (bus.word_ready !== 1'b1) begin failures++; $display("FAIL basic_end_ready: got %b expected 1", bus.word_ready); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_bits;
    logic [5:0]  det;
    int          fires;
    exp_bits = 16'h3330;
    det      = '0;
    fires    = 0;
    bus.word_valid = 1'b1;
    bus.word_data  = 8'h33;
    bus.bit_ready  = 1'b1;
    tick();
    bus.word_data = 8'h30;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      asserts++; if (bus.bit_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid[%0d]: got %b expected 1", i, bus.bit_valid); end
      asserts++; if (bus.new_bit !== exp_bits[15-i]) begin failures++; $display("FAIL b2b_bit[%0d]: got %b expected %b", i, bus.new_bit, exp_bits[15-i]); end
      asserts++; if (bus.word_ready !== (i == 7 || i == 15)) begin failures++; $display("FAIL b2b_ready[%0d]: got %b expected %b", i, bus.word_ready, (i == 7 || i == 15)); end
      asserts++; if (bus.bit_last !== (i == 7 || i == 15)) begin failures++; $display("FAIL b2b_last[%0d]: got %b expected %b", i, bus.bit_last, (i == 7 || i == 15)); end
      if (bus.bit_valid && bus.bit_ready) begin
        det = {det[4:0], bus.new_bit};
        if (det == 6'b110011) begin
          fires++;
          det = '0;
        end
      end
      tick();
      if (i == 7) begin
        bus.word_valid = 1'b0;
        bus.word_data  = 8'hFF;
      end
    end
    @(negedge clk);
    asserts++; if (bus.bit_valid !== 1'b0) begin failures++; $display("FAIL b2b_end_valid: got %b expected 0", bus.bit_valid); end
    asserts++; if (fires != 1) begin failures++; $display("FAIL b2b_detector: got %0d expected 1", fires); end
  endtask

  task automatic test_stall();
    logic [7:0] exp_word;
    exp_word = 8'hA5;
    bus.word_valid = 1'b1;
    bus.word_data  = exp_word;
    bus.bit_ready  = 1'b1;
    tick();
    bus.word_valid = 1'b0;
    bus.word_data  = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        bus.bit_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          asserts++; if (bus.new_bit !== 1'b1) begin failures++; $display("FAIL stall_bit[%0d]: got %b expected 1", s, bus.new_bit); end
          asserts++; if (bus.bit_valid !== 1'b1) begin failures++; $display("FAIL stall_valid[%0d]: got %b expected 1", s, bus.bit_valid); end
          asserts++; if (bus.bit_last !== 1'b0) begin failures++; $display("FAIL stall_last[%0d]: got %b expected 0", s, bus.bit_last); end
          asserts++; if (dbg_count !== CW'(5)) begin failures++; $display("FAIL stall_count[%0d]: got %0d expected 5", s, dbg_count); end
          tick();
        end
        bus.bit_ready = 1'b1;
      end
      @(negedge clk);
      asserts++; if (bus.new_bit !== exp_word[7-i]) begin failures++; $display("FAIL stall_seq[%0d]: got %b expected %b", i, bus.new_bit, exp_word[7-i]); end
      asserts++; if (bus.bit_last !== (i == 7)) begin failures++; $display("FAIL stall_seq_last[%0d]: got %b expected %b", i, bus.bit_last, (i == 7)); end
      tick();
    end
    @(negedge clk);
    asserts++; if (bus.bit_valid !== 1'b0) begin failures++; $display("FAIL stall_end_valid: got %b expected 0", bus.bit_valid); end
  endtask

  task automatic test_reset_mid_word();
    bus.word_valid = 1'b1;
    bus.word_data  = 8'hFF;
    bus.bit_ready  = 1'b1;
    tick();
    bus.word_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      asserts++; if (bus.new_bit !== 1'b1) begin failures++; $display("FAIL rmid_bit[%0d]: got %b expected 1", i, bus.new_bit); end
      tick();
    end
    // reset with a word offered in the same cycles; reset must win
    rst = 1'b1;
    bus.word_valid = 1'b1;
    bus.word_data  = 8'h81;
    tick();
    @(negedge clk);
    asserts++; if (bus.bit_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid: got %b expected 0", bus.bit_valid); end
    asserts++; if (bus.word_ready !== 1'b1) begin failures++; $display("FAIL rmid_ready: got %b expected 1", bus.word_ready); end
    asserts++; if (bus.new_bit !== 1'b0) begin failures++; $display("FAIL rmid_new_bit: got %b expected 0", bus.new_bit); end
    asserts++; if (dbg_count !== '0) begin failures++; $display("FAIL rmid_count: got %0d expected 0", dbg_count); end
    tick();
    @(negedge clk);
    asserts++; if (dbg_state !== IDLE) begin failures++; $display("FAIL rmid_priority: got %0d expected %0d", dbg_state, IDLE); end
    bus.word_valid = 1'b0;
    rst = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      asserts++; if (bus.bit_valid !== 1'b0) begin failures++; $display("FAIL rmid_residual[%0d]: got %b expected 0", i, bus.bit_valid); end
      tick();
    end
  endtask

  task automatic test_idle();
    bus.word_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.word_data = (i % 2 == 1) ? 8'hFF : 8'h00;
      @(negedge clk);
      asserts++; if (bus.bit_valid !== 1'b0) begin failures++; $display("FAIL idle_valid[%0d]: got %b expected 0", i, bus.bit_valid); end
      asserts++; if (dbg_state !== IDLE) begin failures++; $display("FAIL idle_state[%0d]: got %0d expected %0d", i, dbg_state, IDLE); end
      asserts++; if (dbg_count !== '0) begin failures++; $display("FAIL idle_count[%0d]: got %0d expected 0", i, dbg_count); end
      tick();
    end
  endtask

  task automatic test_final_stall();
    logic [7:0] first_word;
    logic [7:0] next_word;
    first_word = 8'h0F;
    next_word  = 8'hF0;
    bus.word_valid = 1'b1;
    bus.word_data  = first_word;
    bus.bit_ready  = 1'b1;
    tick();
    bus.word_data = next_word;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      asserts++; if (bus.new_bit !== first_word[7-i]) begin failures++; $display("FAIL fstall_bit[%0d]: got %b expected %b", i, bus.new_bit, first_word[7-i]); end
      tick();
    end
    bus.bit_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      asserts++; if (bus.word_ready !== 1'b0) begin failures++; $display("FAIL fstall_ready[%0d]: got %b expected 0", s, bus.word_ready); end
      asserts++; if (bus.bit_last !== 1'b1) begin failures++; $display("FAIL fstall_last[%0d]: got %b expected 1", s, bus.bit_last); end
      asserts++; if (bus.new_bit !== 1'b1) begin failures++; $display("FAIL fstall_held[%0d]: got %b expected 1", s, bus.new_bit); end
      tick();
    end
    bus.bit_ready = 1'b1;
    @(negedge clk);
    asserts++; if (bus.word_ready !== 1'b1) begin failures++; $display("FAIL fstall_release: got %b expected 1", bus.word_ready); end
    tick();
    bus.word_valid = 1'b0;
    bus.word_data  = 8'h00;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      asserts++; if (bus.new_bit !== next_word[7-i]) begin failures++; $display("FAIL fstall_next[%0d]: got %b expected %b", i, bus.new_bit, next_word[7-i]); end
      asserts++; if (bus.bit_last !== (i == 7)) begin failures++; $display("FAIL fstall_next_last[%0d]: got %b expected %b", i, bus.bit_last, (i == 7)); end
      tick();
    end
    @(negedge clk);
    asserts++; if (bus.bit_valid !== 1'b0) begin failures++; $display("FAIL fstall_end_valid: got %b expected 0", bus.bit_valid); end
  endtask

  initial begin
    asserts  = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_reset_mid_word();
    test_idle();
    test_final_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
